// File: rtl/scanreg_chain.sv
// scanreg_chain
// -------------
// Parametrised scan register for a serial test chain. Each instance holds a
// WIDTH-bit shift stage that either captures a parallel word or shifts
// serially in either direction. An optional shadow register decouples the
// functional output from shifting. A saturating counter reports how many
// shifts have happened since the last capture or reset, and a flag marks a
// complete frame.
//
// Vectors are indexed [0:WIDTH-1]. Bit 0 is the leftmost bit of a literal.
//
// Ports
//   clk   : clock; all state updates on the rising edge
//   rst   : synchronous active-high reset (overrides every other control)
//   en    : operation enable; 0 holds stage, cnt and full
//   test  : 0 = parallel capture of data, 1 = serial shift
//   dir   : 0 = shift toward bit WIDTH-1, 1 = shift toward bit 0
//   sin   : serial scan input
//   data  : parallel capture input
//   upd   : update strobe, copies the stage into out (SHADOW=1 only)
//   sout  : serial scan output, taken from the stage end selected by dir
//   out   : functional parallel output
//   cnt   : shifts since last capture/reset, saturating at WIDTH
//   full  : high when cnt == WIDTH
module scanreg_chain #(
  parameter int               WIDTH  = 4,
  parameter bit               SHADOW = 1'b1,
  parameter logic [0:WIDTH-1] INIT   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         test,
  input  logic                         dir,
  input  logic                         sin,
  input  logic [0:WIDTH-1]             data,
  input  logic                         upd,
  output logic                         sout,
  output logic [0:WIDTH-1]             out,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         full
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

  logic [0:WIDTH-1] stage_reg;
  logic [0:WIDTH-1] stage_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic             full_reg;

  // Candidate shift results for both directions. sin enters at the end
  // opposite to the one that sout reads for the same direction.
  logic [0:WIDTH-1] shift_up;   // dir=0: data moves toward bit WIDTH-1
  logic [0:WIDTH-1] shift_dn;   // dir=1: data moves toward bit 0

  assign shift_up[0]       = sin;
  assign shift_dn[WIDTH-1] = sin;

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift_up
      assign shift_up[gi] = stage_reg[gi-1];
    end
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift_dn
      assign shift_dn[gi] = stage_reg[gi+1];
    end
  endgenerate

  // Next-state selection for the stage and the frame counter.
  always_comb begin
    stage_next = stage_reg;
    cnt_next   = cnt_reg;
    if (en) begin
      if (!test) begin
        stage_next = data;
        cnt_next   = '0;
      end else begin
        stage_next = dir ? shift_dn : shift_up;
        // Saturate rather than wrap so that full stays asserted on over-shift.
        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= INIT;
      cnt_reg   <= '0;
      full_reg  <= 1'b0;
    end else begin
      stage_reg <= stage_next;
      cnt_reg   <= cnt_next;
      // full is registered with cnt so the two never disagree.
      full_reg  <= (cnt_next == CNT_MAX);
    end
  end

  // sout only ever comes from flops; dir picks which end of the stage is
  // presented, so a dir change is visible without waiting for an edge.
  assign sout = dir ? stage_reg[0] : stage_reg[WIDTH-1];
  assign cnt  = cnt_reg;
  assign full = full_reg;

  generate
    if (SHADOW) begin : g_shadow
      logic [0:WIDTH-1] out_reg;

      // The update copies the pre-edge stage, so an update on the same edge
      // as a capture or shift still publishes the old frame.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_reg <= INIT;
        end else if (upd) begin
          out_reg <= stage_reg;
        end
      end

      assign out = out_reg;
    end else begin : g_direct
      // Without a shadow the functional output is the stage itself, and the
      // update strobe has nothing to do.
      logic unused_upd;
      assign unused_upd = upd;
      assign out        = stage_reg;
    end
  endgenerate

endmodule

// File: tb/tb_scanreg_chain.sv
// Bench for scanreg_chain. Two instances share every input: u_sh (SHADOW=1)
// and u_ds (SHADOW=0, whose out exposes the shift stage directly). Each step
// drives the inputs, pushes the expected post-edge state into a scoreboard
// queue, then pops and compares one edge later.
module tb_scanreg_chain;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, test, dir, sin, upd;
  logic [0:W-1] data;

  logic         sout_sh, sout_ds;
  logic [0:W-1] out_sh, out_ds;
  logic [2:0]   cnt_sh, cnt_ds;
  logic         full_sh, full_ds;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scanreg_chain #(.WIDTH(W), .SHADOW(1'b1), .INIT(4'b0000)) u_sh (
    .clk(clk), .rst(rst), .en(en), .test(test), .dir(dir), .sin(sin),
    .data(data), .upd(upd), .sout(sout_sh), .out(out_sh), .cnt(cnt_sh),
    .full(full_sh)
  );

  scanreg_chain #(.WIDTH(W), .SHADOW(1'b0), .INIT(4'b0000)) u_ds (
    .clk(clk), .rst(rst), .en(en), .test(test), .dir(dir), .sin(sin),
    .data(data), .upd(upd), .sout(sout_ds), .out(out_ds), .cnt(cnt_ds),
    .full(full_ds)
  );

  typedef struct {
    logic [0:W-1] stage;
    logic [0:W-1] shout;
    int           cnt;
    logic         full;
    logic         sout;
  } exp_t;

  exp_t sb[$];

  // Behavioural reference state
  logic [0:W-1] m_stage = '0;
  logic [0:W-1] m_out   = '0;
  int           m_cnt   = 0;
  int           step_no = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic t,
                      input logic d, input logic s, input logic u,
                      input logic [0:W-1] dt);
    exp_t x;
    rst = r; en = e; test = t; dir = d; sin = s; upd = u; data = dt;
    if (r) begin
      m_stage = '0;
      m_out   = '0;
      m_cnt   = 0;
    end else begin
      if (u) m_out = m_stage;
      if (e) begin
        if (!t) begin
          m_stage = dt;
          m_cnt   = 0;
        end else begin
          m_stage = d ? {m_stage[1:W-1], s} : {s, m_stage[0:W-2]};
          if (m_cnt < W) m_cnt++;
        end
      end
    end
    x.stage = m_stage;
    x.shout = m_out;
    x.cnt   = m_cnt;
    x.full  = (m_cnt == W);
    x.sout  = d ? m_stage[0] : m_stage[W-1];
    sb.push_back(x);

    @(posedge clk);
    #1;
    step_no++;
    x = sb.pop_front();
    $display("step %0d rst=%b en=%b test=%b dir=%b sin=%b upd=%b data=%b -> stage=%b out=%b cnt=%0d full=%b sout=%b",
             step_no, r, e, t, d, s, u, dt, out_ds, out_sh, cnt_sh, full_sh, sout_sh);
    check("stage", 32'(out_ds), 32'(x.stage));
    check("shadow_out", 32'(out_sh), 32'(x.shout));
    check("cnt", 32'(cnt_sh), 32'(x.cnt));
    check("cnt_noshadow", 32'(cnt_ds), 32'(x.cnt));
    check("full", 32'(full_sh), 32'(x.full));
    check("sout", 32'(sout_sh), 32'(x.sout));
    check("sout_noshadow", 32'(sout_ds), 32'(x.sout));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; test = 1'b1; dir = 1'b0; sin = 1'b1;
    upd = 1'b0; data = '0;

    // 1. Reset held for two edges while shifting ones in
    step(1, 1, 1, 0, 1, 0, 4'b0000);
    step(1, 1, 1, 0, 1, 0, 4'b0000);
    check("reset_stage", 32'(out_ds), 32'h0);
    check("reset_out", 32'(out_sh), 32'h0);
    check("reset_cnt", 32'(cnt_sh), 32'h0);

    // 2. Capture 0011, then update the shadow with the stage on hold
    step(0, 1, 0, 0, 0, 0, 4'b0011);
    check("cap_stage", 32'(out_ds), 32'(4'b0011));
    check("cap_sout", 32'(sout_sh), 32'h1);
    check("cap_out_unchanged", 32'(out_sh), 32'h0);
    step(0, 0, 0, 0, 0, 1, 4'b0000);
    check("upd_out", 32'(out_sh), 32'(4'b0011));

    // 3. Shift dir=0 with sin = 1,1,0,1; then over-shift; then capture
    step(0, 1, 1, 0, 1, 0, 4'b0000);
    step(0, 1, 1, 0, 1, 0, 4'b0000);
    step(0, 1, 1, 0, 0, 0, 4'b0000);
    step(0, 1, 1, 0, 1, 0, 4'b0000);
    check("frame_stage", 32'(out_ds), 32'(4'b1011));
    check("frame_full", 32'(full_sh), 32'h1);
    step(0, 1, 1, 0, 0, 0, 4'b0000);
    check("sat_cnt", 32'(cnt_sh), 32'h4);
    step(0, 1, 0, 0, 0, 0, 4'b0011);
    check("cap_clears_cnt", 32'(cnt_sh), 32'h0);

    // 4. Shift dir=1 from 0011 with sin=0, then flip dir without an edge
    step(0, 1, 1, 1, 0, 0, 4'b0000);
    check("dir1_stage", 32'(out_ds), 32'(4'b0110));
    dir = 1'b0;
    #1;
    check("dir_flip_sout", 32'(sout_sh), 32'h0);
    step(0, 1, 0, 0, 0, 0, 4'b0011);
    dir = 1'b1;
    #1;
    check("dir_flip_sout_b", 32'(sout_sh), 32'h0);
    dir = 1'b0;
    #1;
    check("dir_flip_sout_c", 32'(sout_sh), 32'h1);

    // 5. Update on the same edge as a shift publishes the pre-shift stage
    step(0, 1, 1, 0, 1, 1, 4'b0000);
    check("same_edge_out", 32'(out_sh), 32'(4'b0011));
    check("same_edge_stage", 32'(out_ds), 32'(4'b1001));
    step(0, 0, 1, 0, 0, 0, 4'b1111);
    step(0, 0, 1, 0, 1, 0, 4'b1111);
    step(0, 0, 0, 1, 0, 0, 4'b1111);
    check("hold_stage", 32'(out_ds), 32'(4'b1001));
    check("hold_cnt", 32'(cnt_sh), 32'h1);

    // 6. Reset mid-frame, with upd asserted alongside both shifts and reset
    step(0, 1, 0, 0, 0, 0, 4'b0101);
    step(0, 1, 1, 0, 1, 1, 4'b0000);
    step(0, 1, 1, 1, 1, 1, 4'b0000);
    step(1, 1, 1, 0, 1, 1, 4'b0000);
    check("midframe_rst_stage", 32'(out_ds), 32'h0);
    check("midframe_rst_out", 32'(out_sh), 32'h0);
    check("midframe_rst_full", 32'(full_sh), 32'h0);

    // Mixed random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
           1'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
